blockram_request_engine: RTL

- Initiator-side front end for dual_port_blockram.
- Accepts independent read and write requests from clients over valid/ack handshakes and drives the RAM's read and write ports.
- Captures read data and evicted data one cycle after issue and returns them through buffered valid/ack response channels.
- Sits between cache/queue logic and the RAM, so clients never track RAM latency or back-pressure.

---
 rtl/blockram_request_engine_pkg.sv | 24 ++
 rtl/blockram_response_fifo.sv | 60 ++++++
 rtl/blockram_request_engine.sv | 119 +++++++++++
 3 files changed

// File: rtl/blockram_request_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blockram_request_engine_pkg
// Description : Default geometry and acceptance rule for the blockram engine.
// Revision    : 1.0 - initial release
// ============================================================================
package blockram_request_engine_pkg;

    localparam int c_element_bits = 64;
    localparam int c_number_sets  = 64;
    localparam int c_set_ptr_bits = 6;
    localparam int c_fifo_depth   = 2;

    // A request may issue only if its response is guaranteed a FIFO slot.
    function automatic logic can_accept(input logic [1:0] occupancy,
                                        input logic       inflight,
                                        input logic       pop);
        logic [2:0] level;
        level = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
        return level < 3'(c_fifo_depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blockram_response_fifo.sv
`default_nettype none
// ============================================================================
// Module      : blockram_response_fifo
// Description : 2-entry fall-through response FIFO with occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module blockram_response_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occupancy
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_empty;
    logic w_pop;
    logic w_store;
    logic w_drop_head;

    // An empty FIFO presents the capture directly so data is seen one cycle after issue.
    assign w_empty     = (r_count == 2'd0);
    assign o_valid     = !w_empty || i_push;
    assign o_data      = w_empty ? i_push_data : r_mem[r_rd_ptr];
    assign o_occupancy = r_count;

    assign w_pop       = i_pop && o_valid;
    assign w_store     = i_push && !(w_empty && w_pop);
    assign w_drop_head = w_pop && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_drop_head) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_drop_head};
        end
    end

endmodule
`default_nettype wire

// File: rtl/blockram_request_engine.sv
`default_nettype none
// ============================================================================
// Module      : blockram_request_engine
// Description : Read/write request front end for dual_port_blockram with
//               buffered read-data and evict-data response channels.
// Revision    : 1.0 - initial release
// ============================================================================
module blockram_request_engine
    import blockram_request_engine_pkg::*;
#(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = c_element_bits,
    parameter int NUMBER_SETS                 = c_number_sets,
    parameter int SET_PTR_WIDTH_IN_BITS       = c_set_ptr_bits
) (
    input  logic                                   clk_in,
    input  logic                                   reset_in,
    input  logic                                   read_req_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_req_addr_in,
    output logic                                   read_req_ack_out,
    output logic                                   read_resp_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_resp_data_out,
    input  logic                                   read_resp_ack_in,
    input  logic                                   write_req_valid_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_req_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_req_data_in,
    output logic                                   write_req_ack_out,
    output logic                                   write_resp_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_resp_evict_out,
    input  logic                                   write_resp_ack_in,
    output logic                                   ram_read_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_read_set_addr_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in,
    output logic                                   ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_write_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_evict_element_in
);

    generate
        if ((1 << SET_PTR_WIDTH_IN_BITS) < NUMBER_SETS) begin : g_bad_addr_width
            $error("SET_PTR_WIDTH_IN_BITS too narrow for NUMBER_SETS");
        end
    endgenerate

    logic                                   r_rd_inflight;
    logic                                   r_wr_inflight;
    logic                                   r_bypass;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] r_bypass_data;

    logic [1:0]                             w_rd_occ;
    logic [1:0]                             w_wr_occ;
    logic                                   w_rd_pop;
    logic                                   w_wr_pop;
    logic                                   w_rd_ack;
    logic                                   w_wr_ack;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] w_rd_capture;

    assign w_rd_pop = read_resp_valid_out && read_resp_ack_in;
    assign w_wr_pop = write_resp_valid_out && write_resp_ack_in;

    assign w_rd_ack = read_req_valid_in && !reset_in &&
                      can_accept(w_rd_occ, r_rd_inflight, w_rd_pop);
    assign w_wr_ack = write_req_valid_in && !reset_in &&
                      can_accept(w_wr_occ, r_wr_inflight, w_wr_pop);

    assign read_req_ack_out       = w_rd_ack;
    assign write_req_ack_out      = w_wr_ack;
    assign ram_read_en_out        = w_rd_ack;
    assign ram_write_en_out       = w_wr_ack;
    assign ram_read_set_addr_out  = w_rd_ack ? read_req_addr_in  : '0;
    assign ram_write_set_addr_out = w_wr_ack ? write_req_addr_in : '0;
    assign ram_write_element_out  = w_wr_ack ? write_req_data_in : '0;

    // The RAM reads old data on a same-address collision; substitute the write.
    assign w_rd_capture = r_bypass ? r_bypass_data : ram_read_element_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_rd_inflight <= 1'b0;
            r_wr_inflight <= 1'b0;
            r_bypass      <= 1'b0;
            r_bypass_data <= '0;
        end else begin
            r_rd_inflight <= w_rd_ack;
            r_wr_inflight <= w_wr_ack;
            r_bypass      <= w_rd_ack && w_wr_ack &&
                             (read_req_addr_in == write_req_addr_in);
            r_bypass_data <= write_req_data_in;
        end
    end

    blockram_response_fifo #(
        .WIDTH(SINGLE_ELEMENT_SIZE_IN_BITS)
    ) u_read_fifo (
        .clk        (clk_in),
        .rst        (reset_in),
        .i_push     (r_rd_inflight),
        .i_push_data(w_rd_capture),
        .i_pop      (read_resp_ack_in),
        .o_valid    (read_resp_valid_out),
        .o_data     (read_resp_data_out),
        .o_occupancy(w_rd_occ)
    );

    blockram_response_fifo #(
        .WIDTH(SINGLE_ELEMENT_SIZE_IN_BITS)
    ) u_write_fifo (
        .clk        (clk_in),
        .rst        (reset_in),
        .i_push     (r_wr_inflight),
        .i_push_data(ram_evict_element_in),
        .i_pop      (write_resp_ack_in),
        .o_valid    (write_resp_valid_out),
        .o_data     (write_resp_evict_out),
        .o_occupancy(w_wr_occ)
    );

endmodule
`default_nettype wire
